// File: rtl/ntt_idx_gen.sv
// ntt_idx_gen: linear index sequencer (0..2^(RADIX_K1*l)-1) feeding the bit-reversal stage.
// Optional NTT_IDX_GEN_MULTIPASS_EN repeats the sweep pass_cfg+1 times per start.
module ntt_idx_gen #(
  parameter int D_WIDTH  = 12,
  parameter int RADIX_K1 = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [D_WIDTH-1:0] l_cfg,
  input  logic               abort,
  input  logic               out_ready,
  output logic [D_WIDTH-1:0] idx_out,
  output logic               idx_valid,
  output logic [D_WIDTH-1:0] l_out,
  output logic               idx_last,
  output logic               rev_valid,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
`ifdef NTT_IDX_GEN_MULTIPASS_EN
  ,
  input  logic [3:0]         pass_cfg,
  output logic [3:0]         pass_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state_q;
  logic [D_WIDTH-1:0]   idx_q, l_q;
  logic [D_WIDTH:0]     tc_q, tc_d;
  logic [D_WIDTH+3:0]   w_d;
  logic                 legal_d, accept, at_tc;
  logic                 vld_q, rev_q, busy_q, done_q, err_q;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
  logic [3:0]           pass_cfg_q, pass_cnt_q;
`endif

  // Width is formed wide enough that an oversized l_cfg cannot wrap into a legal value.
  assign w_d     = (D_WIDTH+4)'(RADIX_K1) * {4'b0, l_cfg};
  assign legal_d = (w_d <= (D_WIDTH+4)'(D_WIDTH));

  always_comb begin
    tc_d = '0;
    for (int i = 0; i <= D_WIDTH; i++)
      tc_d[i] = ((D_WIDTH+4)'(i) < w_d);
  end

  assign accept = vld_q & out_ready;
  assign at_tc  = ({1'b0, idx_q} == tc_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      l_q     <= '0;
      tc_q    <= '0;
      vld_q   <= 1'b0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
      pass_cfg_q <= '0;
      pass_cnt_q <= '0;
`endif
    end else begin
      // Not gated by abort: an index accepted in the abort cycle still reaches BitRev.
      rev_q  <= accept;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
`ifdef NTT_IDX_GEN_MULTIPASS_EN
            pass_cnt_q <= '0;
`endif
            if (legal_d) begin
              l_q     <= l_cfg;
              tc_q    <= tc_d;
              idx_q   <= '0;
              err_q   <= 1'b0;
              vld_q   <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= RUN;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
              pass_cfg_q <= pass_cfg;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (accept) begin
            if (!at_tc) begin
              idx_q <= idx_q + 1'b1;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
            end else if (pass_cnt_q != pass_cfg_q) begin
              idx_q      <= '0;
              pass_cnt_q <= pass_cnt_q + 4'd1;
`endif
            end else begin
              vld_q   <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign idx_out   = idx_q;
  assign idx_valid = vld_q;
  assign l_out     = l_q;
  assign idx_last  = vld_q & at_tc;
  assign rev_valid = rev_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = err_q;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
  assign pass_cnt  = pass_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_idx_gen.sv
// Scoreboard bench for ntt_idx_gen: stimulus pushes expected accept/done events, a negedge monitor pops them.
module tb_ntt_idx_gen;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst, start, abort, out_ready;
  logic [DW-1:0] l_cfg, idx_out, l_out;
  logic          idx_valid, idx_last, rev_valid, busy, done, cfg_err;
`ifdef NTT_IDX_GEN_MULTIPASS_EN
  logic [3:0]    pass_cnt;
`endif

  typedef struct {
    bit is_done;
    int idx;
    bit last;
    int lo;
    int cyc;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  total = 0, bad = 0, cyc = 0;
  int  s;
  bit  prev_acc = 1'b0, prev_rst = 1'b1;

  ntt_idx_gen #(.D_WIDTH(DW), .RADIX_K1(1)) dut (
    .clk(clk), .rst(rst), .start(start), .l_cfg(l_cfg), .abort(abort),
    .out_ready(out_ready), .idx_out(idx_out), .idx_valid(idx_valid),
    .l_out(l_out), .idx_last(idx_last), .rev_valid(rev_valid), .busy(busy),
    .done(done), .cfg_err(cfg_err)
`ifdef NTT_IDX_GEN_MULTIPASS_EN
    , .pass_cfg(4'd0), .pass_cnt(pass_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start and push the expected events; stall_at<0 means no stall.
  task automatic run(input int l, input int stall_at, input int stall_len,
                     input int n_push, input bit push_done, output int st);
    int n;
    ev_t x;
    @(posedge clk);
    #1;
    start = 1'b1;
    l_cfg = DW'(l);
    st    = cyc;
    for (int i = 0; i < n_push; i++) begin
      n = 1 << l;
      x.is_done = 1'b0;
      x.idx     = i;
      x.last    = (i == n - 1);
      x.lo      = l;
      x.cyc     = st + 1 + i + ((stall_at >= 0 && i >= stall_at) ? stall_len : 0);
      q.push_back(x);
    end
    if (push_done) begin
      n = 1 << l;
      x.is_done = 1'b1;
      x.idx     = n - 1;
      x.last    = 1'b0;
      x.lo      = l;
      x.cyc     = st + 1 + n + ((stall_at >= 0) ? stall_len : 0);
      q.push_back(x);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Monitor: pops on every accepted index and every done pulse.
  always @(negedge clk) begin
    if (!rst && !prev_rst) chk("rev_valid", rev_valid, prev_acc);
    if (idx_valid && out_ready) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_idx: got idx %0d want none (cyc %0d)", idx_out, cyc);
      end else begin
        e = q.pop_front();
        chk("evt_is_done", 0, e.is_done);
        chk("idx_out", idx_out, e.idx);
        chk("idx_last", idx_last, e.last);
        chk("l_out", l_out, e.lo);
        chk("idx_cyc", cyc, e.cyc);
      end
    end
    if (done) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 want 0 (cyc %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("evt_is_done", 1, e.is_done);
        chk("done_cyc", cyc, e.cyc);
        chk("done_idx_out", idx_out, e.idx);
        chk("done_busy", busy, 0);
      end
    end
    prev_acc = idx_valid & out_ready;
    prev_rst = rst;
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; l_cfg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_idx_out", idx_out, 0);
    chk("rst_l_out", l_out, 0);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_idx_last", idx_last, 0);
    chk("rst_rev_valid", rev_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(posedge clk); #1; rst = 1'b0;

    // l=3, no stalls: 0..7, done 9 cycles after start
    run(3, -1, 0, 8, 1'b1, s);
    @(negedge clk);
    chk("run_busy", busy, 1);
    chk("run_l_out", l_out, 3);
    to_cyc(s + 11);
    chk("fin_busy", busy, 0);
    chk("fin_idx_hold", idx_out, 7);

    // l=3, out_ready low 3 cycles at index 4
    run(3, 4, 3, 8, 1'b1, s);
    to_cyc(s + 5);
    out_ready = 1'b0;
    to_cyc(s + 6);
    @(negedge clk);
    chk("stall_idx", idx_out, 4);
    chk("stall_valid", idx_valid, 1);
    chk("stall_rev", rev_valid, 0);
    to_cyc(s + 7);
    @(negedge clk);
    chk("stall_idx2", idx_out, 4);
    to_cyc(s + 8);
    out_ready = 1'b1;
    to_cyc(s + 14);

    // l=0: single index 0 with idx_last
    run(0, -1, 0, 1, 1'b1, s);
    to_cyc(s + 4);

    // l=13 overflows: cfg_err, no run
    run(13, -1, 0, 0, 1'b0, s);
    @(negedge clk);
    chk("err_cfg_err", cfg_err, 1);
    chk("err_busy", busy, 0);
    chk("err_valid", idx_valid, 0);
    to_cyc(s + 4);
    run(2, -1, 0, 4, 1'b1, s);
    @(negedge clk);
    chk("err_clear", cfg_err, 0);
    to_cyc(s + 7);

    // abort while index 5 is presented
    run(3, -1, 0, 6, 1'b0, s);
    to_cyc(s + 6);
    abort = 1'b1;
    to_cyc(s + 7);
    abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", idx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    to_cyc(s + 12);

    // start during RUN is ignored
    run(3, -1, 0, 8, 1'b1, s);
    to_cyc(s + 3);
    start = 1'b1; l_cfg = DW'(1);
    to_cyc(s + 4);
    start = 1'b0;
    to_cyc(s + 12);

    // rst mid-run clears everything
    run(3, -1, 0, 3, 1'b0, s);
    to_cyc(s + 3);
    rst = 1'b1;
    to_cyc(s + 4);
    @(negedge clk);
    chk("mrst_idx_out", idx_out, 0);
    chk("mrst_l_out", l_out, 0);
    chk("mrst_valid", idx_valid, 0);
    chk("mrst_last", idx_last, 0);
    chk("mrst_rev", rev_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    to_cyc(s + 5);
    rst = 1'b0;
    to_cyc(s + 8);

    // W == D_WIDTH: full 4096-entry sweep, no wrap
    run(12, -1, 0, 4096, 1'b1, s);
    to_cyc(s + 4100);
    chk("full_idx_hold", idx_out, 4095);

    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ntt_idx_gen.md
Name: ntt_idx_gen

Overview:
- Index sequencer directly upstream of the bit-reversal stage in the NWC/NTT datapath.
- On `start`, emits the linear index sequence 0..N-1, with N = 2^(RADIX_K1*l), one index per accepted cycle.
- Drives the bit-reversal stage's index, enable and digit-count inputs, and delays its own valid to align with that stage's 1-cycle registered output.
- Owns the start/busy/done handshake toward the NTT controller.

Parameters:
- D_WIDTH, 12, width of index, l and digit-count fields; matches `D_width.
- RADIX_K1, 1, bits per radix digit; matches `radix_k1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  1-cycle request to begin a sequence; sampled only in IDLE.
- l_cfg  in  D_WIDTH  number of radix digits, l; sampled with start.
- abort  in  1  return to IDLE next cycle; no done pulse.
- out_ready  in  1  downstream accepts idx_out this cycle.
- idx_out  out  D_WIDTH  current linear index; feeds input_idx.
- idx_valid  out  1  idx_out valid; feeds BitRev_enable.
- l_out  out  D_WIDTH  latched l_cfg; feeds l; stable for the whole run.
- idx_last  out  1  idx_out == N-1 while idx_valid.
- rev_valid  out  1  idx_valid & out_ready delayed 1 cycle; qualifies BitRev_out.
- busy  out  1  high in RUN.
- done  out  1  1-cycle pulse after last index accepted.
- cfg_err  out  1  sticky until next start: the requested width overflowed.

Behaviour:
- Synchronous reset (rst=1 at posedge): state=IDLE; idx_out, l_out, idx_valid, idx_last, rev_valid, busy, done, cfg_err all 0.
- Width rule: W = RADIX_K1*l_cfg, computed at D_WIDTH+4 bits, no truncation.
  - Legal if W <= D_WIDTH.
  - Terminal count TC = (1<<W)-1, held in a D_WIDTH+1-bit register.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - On start with legal W: latch l_out=l_cfg and TC, idx_out=0, cfg_err=0, go RUN.
  - On start with illegal W: cfg_err=1, stay IDLE, no done.
  - start is ignored outside IDLE.
- RUN: idx_valid=1, busy=1.
  - Handshake: an index is accepted when idx_valid & out_ready.
  - Not accepted: idx_out and idx_last hold stable.
  - Accepted and idx_out != TC: idx_out++.
  - Accepted and idx_out == TC: idx_valid drops next cycle, go FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
  - idx_out is retained at TC until the next start.
- Latency:
  - First idx_valid is the cycle after start.
  - Back-to-back throughput is 1 index/cycle with out_ready held high.
  - done asserts 1 cycle after the last acceptance.
  - A full run with no stalls is N+1 cycles from start to done.
- rev_valid = registered (idx_valid & out_ready); not gated by abort, so the final in-flight index still qualifies.
- abort:
  - In RUN or FIN, go IDLE next cycle.
  - idx_valid and busy drop, no done pulse.
  - abort takes priority over a simultaneous last acceptance.
- Boundaries:
  - l_cfg=0 gives N=1: single index 0, idx_last=1 on the first valid cycle.
  - W==D_WIDTH is legal: idx_out wraps never, because TC is compared before increment.
- rst mid-run overrides everything, including a pending done.

Optional Feature:
- Macro: NTT_IDX_GEN_MULTIPASS_EN.
- Defined:
  - Adds input pass_cfg[3:0] (sampled with start) and output pass_cnt[3:0].
  - RUN repeats the 0..TC sweep pass_cfg+1 times with no bubble between passes; idx_out returns to 0 the cycle after TC is accepted.
  - idx_last pulses at the end of every pass.
  - done fires only after the final pass.
  - pass_cnt counts up from 0 and resets to 0 on start and rst.
- Not defined: single pass only; no pass_cfg or pass_cnt ports.

Test Plan:
- RADIX_K1=1, l_cfg=3, start, out_ready=1:
  - idx_out 0..7 on consecutive cycles; idx_last with 7.
  - rev_valid trails idx_valid by 1 cycle.
  - done 9 cycles after start; l_out=3 throughout.
- l_cfg=3, out_ready low for 3 cycles at idx_out=4: idx_out holds 4, idx_valid=1, rev_valid=0 during the stall; resumes at 5; done delayed by 3 cycles.
- l_cfg=0: single index 0 with idx_last=1; done next cycle.
- D_WIDTH=12, RADIX_K1=1, l_cfg=13: cfg_err=1, busy stays 0, no done. Then start with l_cfg=2: cfg_err clears and 0..3 is emitted.
- Back-end cases:
  - abort at idx_out=5 of l_cfg=3: IDLE next cycle, no done.
  - start pulsed during RUN: ignored, sequence unchanged.
  - rst mid-run: all outputs 0 next cycle.
- With NTT_IDX_GEN_MULTIPASS_EN, l_cfg=1, pass_cfg=2: sequence 0,1,0,1,0,1; idx_last at each 1; pass_cnt 0→1→2; single done at the end.
